// File: rtl/jpeg_byte_feeder.sv
// rtl/jpeg_byte_feeder.sv - JPEG byte feeder: FIFO word splitter, unstuffer and marker tagger
//
// Pops 32-bit words from a first-word-fall-through FIFO and turns them into a
// byte stream for the JPEG header/entropy decoder. FF00 collapses to a literal
// FF, FF fill bytes are dropped, and the byte after an FF prefix is flagged as
// a marker code. Once EOI (FFD9) has been emitted, no further bytes are
// fetched or consumed until flush or reset.
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   sys_rst      in   asynchronous active-low reset
//   flush        in   synchronous clear; takes priority over everything else
//   fifo_enable  in   FIFO not empty, fifo_data is valid
//   fifo_data    in   FIFO head word [31:0]
//   fifo_read    out  pop strobe (combinational)
//   out_valid    out  output byte valid
//   out_data     out  output byte [7:0]
//   out_marker   out  out_data is a marker code
//   out_ready    in   downstream accepts the byte
//   eoi_det      out  sticky, EOI marker has been emitted
//   byte_cnt     out  input bytes consumed since reset/flush, saturating

module jpeg_byte_feeder #(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 flush,
    input  logic                 fifo_enable,
    input  logic [31:0]          fifo_data,
    output logic                 fifo_read,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_marker,
    input  logic                 out_ready,
    output logic                 eoi_det,
    output logic [CNT_WIDTH-1:0] byte_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Word currently being split, and the position of the next byte in it.
    logic [31:0] word;
    logic        word_valid;
    logic [1:0]  idx;
    // An FF prefix has been seen and the byte that follows decides its meaning.
    logic        pend;

    logic        adv;
    logic        consume;
    logic        last_byte;
    logic [1:0]  lane;
    logic [7:0]  sel_byte;
    logic        is_ff;
    logic        is_zero;
    logic        emit;
    logic [7:0]  emit_data;
    logic        emit_marker;
    logic        hit_eoi;

    // Output register can take a new byte when empty or being drained.
    assign adv       = ~out_valid | out_ready;
    assign consume   = word_valid & adv & ~eoi_det;
    assign last_byte = consume & (idx == 2'd3);

    // The refill overlaps the last byte of the current word, which is what
    // keeps the stream at one byte per cycle across word boundaries.
    assign fifo_read = fifo_enable & ~flush & ~eoi_det & (~word_valid | last_byte);

    // Big-endian order walks the lanes from the top byte down.
    assign lane = BIG_ENDIAN ? ~idx : idx;

    always_comb begin
        sel_byte = word[7:0];
        case (lane)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
    end

    assign is_ff   = (sel_byte == 8'hFF);
    assign is_zero = (sel_byte == 8'h00);

    // An FF never produces output on its own: either it opens a prefix or,
    // with a prefix already open, it is fill. Every other byte is emitted,
    // either literally, as an unstuffed FF, or as a marker code.
    assign emit        = consume & ~is_ff;
    assign emit_data   = (pend & is_zero) ? 8'hFF : sel_byte;
    assign emit_marker = pend & ~is_zero;
    assign hit_eoi     = emit & emit_marker & (sel_byte == 8'hD9);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            word       <= 32'h0;
            word_valid <= 1'b0;
            idx        <= 2'd0;
            pend       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_marker <= 1'b0;
            eoi_det    <= 1'b0;
            byte_cnt   <= '0;
        end else if (flush) begin
            word       <= 32'h0;
            word_valid <= 1'b0;
            idx        <= 2'd0;
            pend       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_marker <= 1'b0;
            eoi_det    <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            // Word register and read position. A word popped in the same
            // cycle as EOI is kept but never consumed, since consume is
            // blocked from then on.
            if (fifo_read) begin
                word       <= fifo_data;
                word_valid <= 1'b1;
                idx        <= 2'd0;
            end else begin
                if (hit_eoi || last_byte) begin
                    // Bytes following EOI in the same word are discarded.
                    word_valid <= 1'b0;
                end
                if (consume) begin
                    idx <= idx + 2'd1;
                end
            end

            // A prefix survives word boundaries because pend is independent
            // of the word register.
            if (consume) begin
                pend <= is_ff;
            end

            // Output stage: a stalled byte is held untouched because consume
            // (and therefore emit) requires adv.
            if (emit) begin
                out_valid  <= 1'b1;
                out_data   <= emit_data;
                out_marker <= emit_marker;
            end else if (adv) begin
                out_valid  <= 1'b0;
            end

            if (hit_eoi) begin
                eoi_det <= 1'b1;
            end

            // Dropped stuffing and fill bytes count as consumed input.
            if (consume && (byte_cnt != CNT_MAX)) begin
                byte_cnt <= byte_cnt + CNT_ONE;
            end
        end
    end

endmodule
